// File: rtl/disp_src_ctrl.sv
// rtl/disp_src_ctrl.sv - display source switch-over sequencer for SDRAM RD1 and VGA reset
// Debounces the source switches, waits for vsync, then reloads RD1 and pulses the display reset.
module disp_src_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned VS_TIMEOUT  = 2000000,
  parameter logic [22:0] CAM_BASE    = 23'h000000,
  parameter logic [22:0] IMG_BASE    = 23'h100000,
  parameter logic [22:0] IMG_STRIDE  = 23'h04B000,
  parameter int unsigned FRAME_WORDS = 307200
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSW_CAM,
  input  logic [1:0]  iSW_IMG,
  input  logic        iVGA_VS,
  output logic [22:0] oRD_ADDR,
  output logic [22:0] oRD_MAX_ADDR,
  output logic        oRD_LOAD,
  output logic        oDISP_RST_N,
  output logic        oCAM_MODE,
  output logic [1:0]  oIMG_IDX,
  output logic        oBUSY
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int VS_W   = $clog2(VS_TIMEOUT + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VS_W-1:0]   VS_LAST   = VS_W'(VS_TIMEOUT - 1);
  localparam logic [22:0]       FRAME_W   = 23'(FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_VS,
    ST_LOAD
  } state_t;

  state_t state, state_nx;

  logic       cam_s1, cam_s2;
  logic [1:0] img_s1, img_s2;
  logic       vs_s1, vs_s2, vs_d;

  logic [1:0]       cand_idx;
  logic [2:0]       cand, cand_q, stable;
  logic [DEB_W-1:0] deb_cnt;
  logic             chg_evt;

  logic              pending, pending_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [VS_W-1:0]   vs_cnt;
  logic              vs_fall, go_load, hold_done, in_load;

  logic [2:0]  sel;
  logic [22:0] base_calc, max_calc;
  logic [22:0] rd_addr, rd_max_addr;
  logic        cam_mode;
  logic [1:0]  img_idx;

  // vsync idles high, so its synchronizer resets high to avoid a false edge
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cam_s1 <= 1'b0;
      cam_s2 <= 1'b0;
      img_s1 <= 2'b00;
      img_s2 <= 2'b00;
      vs_s1  <= 1'b1;
      vs_s2  <= 1'b1;
      vs_d   <= 1'b1;
    end else begin
      cam_s1 <= iSW_CAM;
      cam_s2 <= cam_s1;
      img_s1 <= iSW_IMG;
      img_s2 <= img_s1;
      vs_s1  <= iVGA_VS;
      vs_s2  <= vs_s1;
      vs_d   <= vs_s2;
    end
  end

  assign cand_idx = {1'b0, img_s2[1]} + {1'b0, img_s2[0]};
  assign cand     = {cam_s2, cand_idx};
  assign vs_fall  = vs_d & ~vs_s2;
  assign chg_evt  = (cand == cand_q) && (deb_cnt == DEB_LAST) && (cand != stable);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cand_q  <= 3'b000;
      deb_cnt <= '0;
      stable  <= 3'b000;
    end else begin
      if (cand != cand_q) begin
        cand_q  <= cand;
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (chg_evt) begin
        stable <= cand;
      end
    end
  end

  assign go_load   = (state == ST_WAIT_VS) && (vs_fall || (vs_cnt == VS_LAST));
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign in_load   = (state == ST_INIT) || (state == ST_LOAD);

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    case (state)
      ST_INIT, ST_LOAD: begin
        pending_nx = pending | chg_evt;
        if (hold_done) begin
          state_nx = ST_IDLE;
        end
      end
      ST_IDLE: begin
        pending_nx = 1'b0;
        if (chg_evt || pending) begin
          state_nx = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        // an event landing on the switch-over cycle is taken directly, not deferred
        pending_nx = pending | (chg_evt & ~go_load);
        if (go_load) begin
          state_nx = ST_LOAD;
        end
      end
      default: begin
        state_nx   = ST_INIT;
        pending_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_INIT;
      pending  <= 1'b0;
      hold_cnt <= '0;
      vs_cnt   <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      if (in_load && !hold_done) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
      if (state != ST_WAIT_VS) begin
        vs_cnt <= '0;
      end else if (!go_load) begin
        vs_cnt <= vs_cnt + 1'b1;
      end
    end
  end

  assign sel       = chg_evt ? cand : stable;
  assign base_calc = sel[2] ? CAM_BASE : (IMG_BASE + IMG_STRIDE * {21'd0, sel[1:0]});
  assign max_calc  = base_calc + FRAME_W;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_addr     <= IMG_BASE;
      rd_max_addr <= IMG_BASE + FRAME_W;
      cam_mode    <= 1'b0;
      img_idx     <= 2'b00;
    end else if (go_load) begin
      rd_addr     <= base_calc;
      rd_max_addr <= max_calc;
      cam_mode    <= sel[2];
      img_idx     <= sel[1:0];
    end
  end

  assign oRD_ADDR     = rd_addr;
  assign oRD_MAX_ADDR = rd_max_addr;
  assign oCAM_MODE    = cam_mode;
  assign oIMG_IDX     = img_idx;
  assign oRD_LOAD     = in_load;
  assign oDISP_RST_N  = ~in_load;
  assign oBUSY        = (state != ST_IDLE);

endmodule
